// File: rtl/mem_pkg.sv
// Shared types and constants for the memory interface between the
// multi-cycle control unit and the unified instruction/data BRAM.
//   req_t       : request kind (fetch, load, store)
//   mem_state_t : sequencer states
//   F3_*        : funct3 size/sign encodings
//   req_aligned : alignment rule for a request
package mem_pkg;

  typedef enum logic [1:0] {
    REQ_FETCH = 2'd0,
    REQ_LOAD  = 2'd1,
    REQ_STORE = 2'd2
  } req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } mem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Size comes from funct3[1:0]; the unused encodings (011, 110, 111) fall
  // into the word case. Fetches are always words.
  function automatic logic req_aligned(req_t kind, logic [2:0] funct3, logic [1:0] offset);
    logic ok;
    if (kind == REQ_FETCH) begin
      ok = (offset == 2'b00);
    end else begin
      case (funct3[1:0])
        2'b00:   ok = 1'b1;
        2'b01:   ok = ~offset[0];
        default: ok = (offset == 2'b00);
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/mem_interface_if.sv
// Request/response and BRAM bus bundle for mem_interface.
//   req_*        : one-cycle request from the control unit
//   mem_ready    : completion pulse, qualified by misaligned
//   rdata        : fetched instruction or aligned load data
//   busy         : sequencer not idle
//   req_dropped  : sticky, a request arrived while busy
//   bram_*       : single-port BRAM connection
// Modports: master = control unit, slave = mem_interface, bram = memory.
interface mem_interface_if #(
  parameter int ADDR_WIDTH = 12
) ();
  import mem_pkg::*;

  logic                  req_valid;
  req_t                  req_type;
  logic [31:0]           req_addr;
  logic [2:0]            req_funct3;
  logic [31:0]           req_wdata;
  logic                  mem_ready;
  logic [31:0]           rdata;
  logic                  busy;
  logic                  misaligned;
  logic                  req_dropped;
  logic                  bram_en;
  logic [3:0]            bram_we;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [31:0]           bram_wdata;
  logic [31:0]           bram_rdata;

  modport master (
    output req_valid, req_type, req_addr, req_funct3, req_wdata,
    input  mem_ready, rdata, busy, misaligned, req_dropped
  );

  modport slave (
    input  req_valid, req_type, req_addr, req_funct3, req_wdata, bram_rdata,
    output mem_ready, rdata, busy, misaligned, req_dropped,
           bram_en, bram_we, bram_addr, bram_wdata
  );

  modport bram (
    input  bram_en, bram_we, bram_addr, bram_wdata,
    output bram_rdata
  );

endinterface

// File: rtl/mem_interface_load_align.sv
// Load data alignment: picks the addressed byte/halfword out of a raw
// 32-bit BRAM word and sign- or zero-extends it according to funct3.
//   raw    : word as read from the BRAM
//   offset : byte offset addr[1:0]
//   funct3 : load size/sign (unused encodings behave as LW)
//   result : aligned, extended load value
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = raw[7:0];
      2'd1:    byte_sel = raw[15:8];
      2'd2:    byte_sel = raw[23:16];
      default: byte_sel = raw[31:24];
    endcase
    half_sel = offset[1] ? raw[31:16] : raw[15:0];

    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   result = {24'd0, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_HU:   result = {16'd0, half_sel};
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/mem_interface.sv
// Single-outstanding memory sequencer between the control unit and the
// unified instruction/data BRAM. Checks alignment, steers store bytes onto
// the BRAM lanes, waits out the BRAM read latency and aligns load data.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : mem_interface_if.slave (request/response + BRAM bus)
//
// state | meaning
// IDLE  | waiting for req_valid, latches the request
// ISSUE | BRAM enabled; stores write here
// WAIT  | read latency countdown, captures read data on zero
// RESP  | one-cycle mem_ready pulse
module mem_interface
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst,
  mem_interface_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ISSUE = ISSUE;
  localparam logic [1:0] ST_WAIT  = WAIT;
  localparam logic [1:0] ST_RESP  = RESP;
  localparam logic [1:0] LAT_INIT = 2'(READ_LATENCY - 1);

  logic [1:0]            state;
  req_t                  type_q;
  // Only the word-address and offset bits are kept; higher bits wrap.
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [2:0]            f3_q;
  logic [31:0]           wdata_q;
  logic                  mis_q;
  logic [1:0]            lat_cnt;
  logic [31:0]           rdata_q;
  logic                  dropped_q;
  logic [31:0]           load_word;
  logic [3:0]            we_mask;
  logic [31:0]           wdata_lane;
  logic                  req_ok;

  assign req_ok = req_aligned(bus.req_type, bus.req_funct3, bus.req_addr[1:0]);

  load_align u_load_align (
    .raw    (bus.bram_rdata),
    .offset (addr_q[1:0]),
    .funct3 (f3_q),
    .result (load_word)
  );

  always_comb begin
    we_mask    = 4'b1111;
    wdata_lane = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        we_mask    = 4'b0001 << addr_q[1:0];
        wdata_lane = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        we_mask    = 4'b0011 << addr_q[1:0];
        wdata_lane = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      type_q    <= REQ_FETCH;
      addr_q    <= '0;
      f3_q      <= '0;
      wdata_q   <= '0;
      mis_q     <= 1'b0;
      lat_cnt   <= '0;
      rdata_q   <= '0;
      dropped_q <= 1'b0;
    end else begin
      if (bus.req_valid && (state != ST_IDLE)) dropped_q <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            type_q  <= bus.req_type;
            addr_q  <= bus.req_addr[ADDR_WIDTH+1:0];
            f3_q    <= (bus.req_type == REQ_FETCH) ? F3_W : bus.req_funct3;
            wdata_q <= bus.req_wdata;
            mis_q   <= ~req_ok;
            state   <= req_ok ? ST_ISSUE : ST_RESP;
          end
        end
        ST_ISSUE: begin
          if (type_q == REQ_STORE) begin
            state <= ST_RESP;
          end else begin
            lat_cnt <= LAT_INIT;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (lat_cnt == 2'd0) begin
            rdata_q <= load_word;
            state   <= ST_RESP;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_ready   = (state == ST_RESP);
  assign bus.misaligned  = (state == ST_RESP) && mis_q;
  assign bus.busy        = (state != ST_IDLE);
  assign bus.req_dropped = dropped_q;
  assign bus.rdata       = rdata_q;
  assign bus.bram_en     = (state == ST_ISSUE) || (state == ST_WAIT);
  assign bus.bram_we     = ((state == ST_ISSUE) && (type_q == REQ_STORE)) ? we_mask : 4'b0000;
  assign bus.bram_addr   = addr_q[ADDR_WIDTH+1:2];
  assign bus.bram_wdata  = wdata_lane;

endmodule

// File: doc/mem_interface.md
Name: mem_interface

Overview:
- Sits between the multi-cycle control unit and the single-port unified instruction/data BRAM.
- Accepts one request at a time: instruction fetch, data load or data store. Drives the BRAM with the configured read latency.
- Performs byte-lane steering for stores and alignment/sign-extension for loads.
- Returns a one-cycle mem_ready pulse that the control unit consumes to gate ir_write, writeback and PC update.

Parameters:
- ADDR_WIDTH, 12, BRAM word-address width (depth = 2**ADDR_WIDTH words of 32 bits).
- READ_LATENCY, 1, BRAM cycles from an enabled read to valid bram_rdata (legal range 1..4).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  single-cycle request strobe.
- req_type  in  2  mem_pkg::req_t: FETCH, LOAD, STORE.
- req_addr  in  32  byte address (PC for FETCH, ALU result for LOAD/STORE).
- req_funct3  in  3  access size/sign; ignored for FETCH (treated as LW).
- req_wdata  in  32  store data (rs2), LSB-justified.
- mem_ready  out  1  one-cycle completion pulse.
- rdata  out  32  instruction word or aligned/extended load data; held until the next completion.
- busy  out  1  high whenever the FSM is not in IDLE.
- misaligned  out  1  qualifies mem_ready: the access was rejected for misalignment.
- req_dropped  out  1  sticky error: a request arrived while busy; cleared only by reset.
- bram_en  out  1  BRAM enable.
- bram_we  out  4  byte write enables.
- bram_addr  out  ADDR_WIDTH  word address, equal to addr[ADDR_WIDTH+1:2]. Upper bits are ignored, so addresses wrap.
- bram_wdata  out  32  lane-steered store data.
- bram_rdata  in  32  BRAM read data.

Behaviour:
- Reset (async, rst=1): the FSM goes to IDLE. mem_ready, busy, misaligned, req_dropped, bram_en and bram_we are all 0. rdata and the address/data latches are 0. Reset mid-access abandons the access with no completion pulse; a BRAM write already issued is not undone.
- States are IDLE, ISSUE, WAIT and RESP.
- IDLE:
  - On req_valid, latch type, addr, funct3 and wdata.
  - Check alignment: halfword needs addr[0]=0; word and FETCH need addr[1:0]=0; byte accesses are always aligned.
  - If misaligned, go to RESP with a misaligned flag set and perform no BRAM access.
  - Otherwise go to ISSUE.
- ISSUE (one cycle):
  - bram_en=1.
  - STORE: assert bram_we, then go to RESP.
  - SB: we=1<<addr[1:0], wdata={4{wdata[7:0]}}.
  - SH: we=3<<addr[1:0], wdata={2{wdata[15:0]}}.
  - SW: we=4'b1111.
  - FETCH/LOAD: we=0; load the latency counter with READ_LATENCY-1 and go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, register bram_rdata into the raw-word latch and go to RESP.
- RESP (one cycle):
  - mem_ready=1 and misaligned=flag.
  - For loads and fetches, rdata updates at entry to RESP, so rdata is valid in the same cycle as mem_ready and is held afterwards.
  - Stores and misaligned accesses leave rdata unchanged.
  - Next state is IDLE.
- Load alignment (from the raw word, using addr[1:0]):
  - LB/LBU: select byte addr[1:0]; sign- or zero-extend.
  - LH/LHU: select halfword addr[1]; sign- or zero-extend.
  - LW: pass the word through.
- Illegal funct3 (011, 110, 111) is treated as LW/SW.
- Latency, with acceptance at cycle T:
  - Store: mem_ready at T+2.
  - Load/fetch: mem_ready at T+2+READ_LATENCY.
  - Misaligned: mem_ready at T+1.
- busy is 1 in ISSUE, WAIT and RESP.
- A req_valid while busy is ignored and sets req_dropped. This includes a request in the RESP cycle. The earliest legal new request is the cycle after mem_ready.
- bram_en is 0 in every state except ISSUE and WAIT. bram_addr is held stable from ISSUE through WAIT.

Decomposition:
- Package mem_pkg holds:
  - req_t enum {REQ_FETCH, REQ_LOAD, REQ_STORE}.
  - mem_state_t enum {IDLE, ISSUE, WAIT, RESP}.
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
- Sub-module load_align: combinational, taking the raw 32-bit word, offset[1:0] and funct3, and producing the 32-bit result. It is instantiated once and unit-testable on its own.
- Store lane steering stays inline.

Test Plan:
- Reset, FETCH addr=0x10, BRAM word4=0x00500093, READ_LATENCY=1 -> bram_addr=4 in ISSUE; mem_ready exactly at T+3 with rdata=0x00500093; busy low at T+4.
- SB addr=0x23 wdata=0x000000AB, then LBU 0x23 and LB 0x23 -> bram_we=4'b1000 with bram_wdata=0xABABABAB; mem_ready at T+2; LBU returns 0x000000AB; LB returns 0xFFFFFFAB.
- Word 8 preset to 0x8001_7FFF; LH 0x20, LH 0x22, LHU 0x22 -> 0x00007FFF, 0xFFFF8001, 0x00008001.
- LW 0x21 and SH 0x23 -> mem_ready at T+1 with misaligned=1; bram_en never asserted; rdata unchanged.
- Request during WAIT and again during RESP -> both ignored; req_dropped=1 and stays set; the original access completes with correct data.
- rst asserted in WAIT with READ_LATENCY=3 -> all outputs 0 immediately (async); no mem_ready follows; a new FETCH after deassert completes normally at T+5.
